// File: rtl/hamming_secded_pkg.sv
// Shared definitions for the (8,4) extended Hamming SECDED encoder/decoder pair.
// Bit 0 carries overall parity; bits 1..7 are Hamming positions 1..7.
package hamming_secded_pkg;

  localparam int P0_BIT = 0;
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_D0 = 3;
  localparam int POS_P4 = 4;
  localparam int POS_D1 = 5;
  localparam int POS_D2 = 6;
  localparam int POS_D3 = 7;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_1BIT,
    ERR_2BIT,
    ERR_PARITY
  } err_class_e;

  function automatic logic [2:0] syndrome(input logic [7:0] cw);
    logic [2:0] s;
    s[0] = cw[1] ^ cw[3] ^ cw[5] ^ cw[7];
    s[1] = cw[2] ^ cw[3] ^ cw[6] ^ cw[7];
    s[2] = cw[4] ^ cw[5] ^ cw[6] ^ cw[7];
    return s;
  endfunction

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] cw;
    cw         = '0;
    cw[POS_D0] = d[0];
    cw[POS_D1] = d[1];
    cw[POS_D2] = d[2];
    cw[POS_D3] = d[3];
    cw[POS_P1] = d[0] ^ d[1] ^ d[3];
    cw[POS_P2] = d[0] ^ d[2] ^ d[3];
    cw[POS_P4] = d[1] ^ d[2] ^ d[3];
    cw[P0_BIT] = ^cw[7:1];
    return cw;
  endfunction

  function automatic logic [3:0] extract_data(input logic [7:0] cw);
    return {cw[POS_D3], cw[POS_D2], cw[POS_D1], cw[POS_D0]};
  endfunction

  function automatic err_class_e classify(input logic [2:0] s, input logic e);
    err_class_e c;
    if (s == 3'd0) c = e ? ERR_PARITY : ERR_NONE;
    else           c = e ? ERR_1BIT   : ERR_2BIT;
    return c;
  endfunction

endpackage

// File: rtl/secded_err_counter.sv
// Saturating event counter; a synchronous clear wins over a same-cycle increment.
module secded_err_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hamming74_secded_rx.sv
// Two-stage streaming SECDED decoder: stage 1 captures the codeword with its
// syndrome/overall parity, stage 2 holds corrected data and the error class.
module hamming74_secded_rx
  import hamming_secded_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cw_valid,
  output logic             o_cw_ready,
  input  logic [7:0]       i_cw,
  output logic             o_data_valid,
  input  logic             i_data_ready,
  output logic [3:0]       o_data,
  output logic             o_1bit_error,
  output logic             o_2bit_error,
  output logic             o_parity_error,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_cnt_1bit,
  output logic [CNT_W-1:0] o_cnt_2bit,
  output logic [CNT_W-1:0] o_cnt_parity
);

  logic       r_s1_valid;
  logic [7:0] r_s1_cw;
  logic [2:0] r_s1_syn;
  logic       r_s1_par;

  logic       r_s2_valid;
  logic [3:0] r_s2_data;
  err_class_e r_s2_class;

  logic       w_adv1;
  logic       w_adv2;
  err_class_e w_class;
  logic [7:0] w_fixed;
  logic       w_out_hs;

  // Ready is combinational from i_data_ready so a full pipe still sustains one word per cycle.
  assign w_adv2     = !r_s2_valid || i_data_ready;
  assign w_adv1     = !r_s1_valid || w_adv2;
  assign o_cw_ready = w_adv1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_cw    <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= i_cw_valid;
      if (i_cw_valid) begin
        r_s1_cw  <= i_cw;
        r_s1_syn <= syndrome(i_cw);
        r_s1_par <= ^i_cw;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_class = classify(r_s1_syn, r_s1_par);
    w_fixed = r_s1_cw;
    if (w_class == ERR_1BIT) w_fixed = r_s1_cw ^ (8'd1 << r_s1_syn);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_class <= ERR_NONE;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data  <= extract_data(w_fixed);
        r_s2_class <= w_class;
      end
    end
  end

  assign o_data_valid   = r_s2_valid;
  assign o_data         = r_s2_data;
  assign o_1bit_error   = r_s2_valid && (r_s2_class == ERR_1BIT);
  assign o_2bit_error   = r_s2_valid && (r_s2_class == ERR_2BIT);
  assign o_parity_error = r_s2_valid && (r_s2_class == ERR_PARITY);

  assign w_out_hs = r_s2_valid && i_data_ready;

  secded_err_counter #(.CNT_W(CNT_W)) u_cnt_1bit (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_cnt_clr),
    .i_inc   (w_out_hs && o_1bit_error),
    .o_cnt   (o_cnt_1bit)
  );

  secded_err_counter #(.CNT_W(CNT_W)) u_cnt_2bit (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_cnt_clr),
    .i_inc   (w_out_hs && o_2bit_error),
    .o_cnt   (o_cnt_2bit)
  );

  secded_err_counter #(.CNT_W(CNT_W)) u_cnt_parity (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_cnt_clr),
    .i_inc   (w_out_hs && o_parity_error),
    .o_cnt   (o_cnt_parity)
  );

endmodule

// File: tb/tb_hamming74_secded_rx.sv
// Bench for hamming74_secded_rx: a default-width and a 2-bit-counter instance share
// stimulus; expected words come from a nearest-codeword decoder and a scoreboard queue.
module tb_hamming74_secded_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cw_valid;
  logic [7:0] cw;
  logic       data_ready;
  logic       cnt_clr;

  logic        cw_ready, data_valid, e1, e2, ep;
  logic [3:0]  data;
  logic [15:0] cnt1, cnt2, cntp;

  logic        s_cw_ready, s_data_valid, s_e1, s_e2, s_ep;
  logic [3:0]  s_data;
  logic [1:0]  s_cnt1, s_cnt2, s_cntp;

  always #5 clk = ~clk;

  hamming74_secded_rx dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cw_valid(cw_valid), .o_cw_ready(cw_ready), .i_cw(cw),
    .o_data_valid(data_valid), .i_data_ready(data_ready), .o_data(data),
    .o_1bit_error(e1), .o_2bit_error(e2), .o_parity_error(ep), .i_cnt_clr(cnt_clr),
    .o_cnt_1bit(cnt1), .o_cnt_2bit(cnt2), .o_cnt_parity(cntp)
  );

  hamming74_secded_rx #(.CNT_W(2)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_cw_valid(cw_valid), .o_cw_ready(s_cw_ready), .i_cw(cw),
    .o_data_valid(s_data_valid), .i_data_ready(data_ready), .o_data(s_data),
    .o_1bit_error(s_e1), .o_2bit_error(s_e2), .o_parity_error(s_ep), .i_cnt_clr(cnt_clr),
    .o_cnt_1bit(s_cnt1), .o_cnt_2bit(s_cnt2), .o_cnt_parity(s_cntp)
  );

  typedef struct {
    logic [3:0] data;
    logic       e1;
    logic       e2;
    logic       ep;
  } exp_t;

  exp_t        q[$];
  int unsigned m_big[3];
  int unsigned m_small[3];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_encode(input logic [3:0] d);
    logic [7:0] c;
    c    = '0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    c[1] = d[0] ^ d[1] ^ d[3];
    c[2] = d[0] ^ d[2] ^ d[3];
    c[4] = d[1] ^ d[2] ^ d[3];
    c[0] = ^c[7:1];
    return c;
  endfunction

  // Decode by minimum Hamming distance to the 16 legal codewords.
  function automatic exp_t ref_decode(input logic [7:0] c);
    exp_t       r;
    int         best_dist;
    logic [3:0] best_d;
    logic [7:0] diff;
    best_dist = 9;
    best_d    = '0;
    for (int d = 0; d < 16; d++) begin
      if ($countones(c ^ ref_encode(4'(d))) < best_dist) begin
        best_dist = $countones(c ^ ref_encode(4'(d)));
        best_d    = 4'(d);
      end
    end
    diff = c ^ ref_encode(best_d);
    r.e1 = 1'b0;
    r.e2 = 1'b0;
    r.ep = 1'b0;
    r.data = best_d;
    if (best_dist == 1) begin
      if (diff == 8'h01) r.ep = 1'b1;
      else               r.e1 = 1'b1;
    end else if (best_dist >= 2) begin
      r.e2   = 1'b1;
      r.data = {c[7], c[6], c[5], c[3]};
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_big[k]   = 0;
      m_small[k] = 0;
    end
  endtask

  task automatic bump(input int k);
    if (m_big[k] < 65535) m_big[k]++;
    if (m_small[k] < 3)   m_small[k]++;
  endtask

  task automatic cycle(input logic v, input logic [7:0] c, input logic r, input logic clr);
    exp_t h;
    @(negedge clk);
    cw_valid   = v;
    cw         = c;
    data_ready = r;
    cnt_clr    = clr;
    #1;
    check("cnt_1bit",     cnt1,   m_big[0]);
    check("cnt_2bit",     cnt2,   m_big[1]);
    check("cnt_parity",   cntp,   m_big[2]);
    check("cnt_1bit_w2",  s_cnt1, m_small[0]);
    check("cnt_2bit_w2",  s_cnt2, m_small[1]);
    check("cnt_parity_w2", s_cntp, m_small[2]);
    if (!data_valid) begin
      check("idle_flags", {e1, e2, ep}, 3'b000);
    end else if (q.size() == 0) begin
      check("spurious_valid", data_valid, 1'b0);
    end else begin
      h = q[0];
      check("data",  data, h.data);
      check("flags", {e1, e2, ep}, {h.e1, h.e2, h.ep});
      if (r) begin
        void'(q.pop_front());
        if (!clr) begin
          if (h.e1) bump(0);
          if (h.e2) bump(1);
          if (h.ep) bump(2);
        end
      end
    end
    if (clr) model_clear();
    if (v && cw_ready) q.push_back(ref_decode(c));
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while ((q.size() != 0 || data_valid) && budget > 0) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      budget--;
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cw_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid",  data_valid, 1'b0);
    check("rst_data",   data, 4'h0);
    check("rst_flags",  {e1, e2, ep}, 3'b000);
    check("rst_cnts",   {cnt1, cnt2, cntp}, 48'h0);
    check("rst_cnts_w2", {s_cnt1, s_cnt2, s_cntp}, 6'h0);
    q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] base;
    logic [7:0] m;
    base = 8'hAA;
    rst_n = 1'b0; cw_valid = 1'b0; cw = '0; data_ready = 1'b1; cnt_clr = 1'b0;
    model_clear();
    do_reset();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("ready_after_reset", cw_ready, 1'b1);

    // Clean back-to-back words with latency check.
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    cycle(1'b1, 8'h00, 1'b1, 1'b0);
    check("lat_plus1_invalid", data_valid, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_plus2_valid", data_valid, 1'b1);
    check("lat_plus2_data", data, 4'hB);
    drain();

    // Every single-bit error position of 8'hAA.
    for (int p = 1; p < 8; p++) cycle(1'b1, base ^ (8'd1 << p), 1'b1, 1'b0);
    drain();
    check("singles_cnt", cnt1, 7);

    cycle(1'b1, 8'hCA, 1'b1, 1'b0);
    cycle(1'b1, 8'hAB, 1'b1, 1'b0);
    drain();
    check("double_cnt", cnt2, 1);
    check("parity_cnt", cntp, 1);

    // Backpressure: third word must wait while two are in flight.
    cycle(1'b1, 8'h8A, 1'b0, 1'b0);
    cycle(1'b1, 8'hCA, 1'b0, 1'b0);
    cycle(1'b1, ref_encode(4'h6), 1'b0, 1'b0);
    check("bp_ready_low", cw_ready, 1'b0);
    check("bp_hold_data", data, 4'hB);
    cycle(1'b1, ref_encode(4'h6), 1'b0, 1'b0);
    check("bp_hold_flag", e1, 1'b1);
    cycle(1'b1, ref_encode(4'h6), 1'b1, 1'b0);
    drain();

    // Saturation of the 2-bit instance.
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h8A, 1'b1, 1'b0);
    drain();
    check("sat_cnt_w2", s_cnt1, 2'd3);
    check("sat_cnt_w16", cnt1, 5);

    // Clear on the same cycle as a flagged handshake.
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b1, 8'h8A, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_priority", cnt1, 0);

    // Reset mid-stream.
    cycle(1'b1, 8'hAB, 1'b1, 1'b0);
    cycle(1'b1, 8'hCA, 1'b0, 1'b0);
    cycle(1'b1, 8'h8A, 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_empty", data_valid, 1'b0);
    check("post_rst_ready", cw_ready, 1'b1);
    cycle(1'b1, 8'h8A, 1'b1, 1'b0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      m = '0;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) m[$urandom_range(0, 7)] = 1'b1;
      cycle(1'($urandom_range(0, 3) != 0), ref_encode(4'($urandom_range(0, 15))) ^ m,
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 49) == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
